// File: rtl/debounce_multi.sv
// debounce_multi: N-channel button debouncer with 2-flop sync, shared sample prescaler,
// per-channel stability counters, clean level and one-cycle press/release pulses.
module debounce_multi #(
    parameter int CH         = 8,
    parameter int STABLE     = 3,
    parameter int DIV        = 1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] level,
    output logic [CH-1:0] press,
    output logic [CH-1:0] rel,
    output logic          any_press
);
    localparam int CW = $clog2(STABLE + 1);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CH-1:0] p, s1, s2;
    logic [DW-1:0] cnt;
    logic          tick;
    assign p         = ACTIVE_LOW ? ~in : in;
    assign tick      = cnt == DW'(DIV - 1);
    assign any_press = |press;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            cnt <= '0;
        end else begin
            s1  <= p;
            s2  <= s1;
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
    // release is a reserved word, so the falling-edge pulse is named rel
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CW-1:0] c;
        logic          lv, pr, rl, differ, done;
        assign differ   = s2[i] ^ lv;
        assign done     = differ && tick && c == CW'(STABLE - 1);
        assign level[i] = lv;
        assign press[i] = pr;
        assign rel[i]   = rl;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                c  <= '0;
                lv <= 1'b0;
                pr <= 1'b0;
                rl <= 1'b0;
            end else begin
                c  <= (!differ || done) ? '0 : tick ? c + 1'b1 : c;
                lv <= done ? s2[i] : lv;
                pr <= done & s2[i];
                rl <= done & ~s2[i];
            end
        end
    end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed checks of debounce_multi at DIV=1, DIV=4 and ACTIVE_LOW=0.
module tb_debounce_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_a, level_a, press_a, rel_a;
    logic [3:0] in_d, level_d, press_d, rel_d;
    logic [3:0] in_p, level_p, press_p, rel_p;
    logic       any_a, any_d, any_p;
    int         checks = 0;
    int         errors = 0;
    int         ecnt = 0;

    debounce_multi #(.CH(4), .STABLE(3), .DIV(1), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .in(in_a), .level(level_a), .press(press_a), .rel(rel_a), .any_press(any_a));
    debounce_multi #(.CH(4), .STABLE(3), .DIV(4), .ACTIVE_LOW(1'b1)) dut_d (
        .clk(clk), .rst(rst), .in(in_d), .level(level_d), .press(press_d), .rel(rel_d), .any_press(any_d));
    debounce_multi #(.CH(4), .STABLE(3), .DIV(1), .ACTIVE_LOW(1'b0)) dut_p (
        .clk(clk), .rst(rst), .in(in_p), .level(level_p), .press(press_p), .rel(rel_p), .any_press(any_p));

    always #5 clk = ~clk;

    // edges since the last reset; with DIV=4 a sample tick lands on every edge number divisible by 4
    always @(posedge clk) ecnt <= rst ? 0 : ecnt + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_a = 4'h0; in_d = 4'hF; in_p = 4'h0;
        step(2);
        checks++;
        if ({level_a, press_a, rel_a, any_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold level=%b press=%b rel=%b any=%b want 0", level_a, press_a, rel_a, any_a);
        end
        rst = 1'b0;
        step(4);
        checks++;
        if (level_a !== 4'h0) begin
            errors++;
            $display("FAIL reset_early level=%b want 0000", level_a);
        end
        step(1);
        checks++;
        if (level_a !== 4'hF || press_a !== 4'hF || rel_a !== 4'h0 || any_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_qualify level=%b press=%b rel=%b any=%b want 1111 1111 0000 1", level_a, press_a, rel_a, any_a);
        end
        step(1);
        checks++;
        if (level_a !== 4'hF || press_a !== 4'h0 || any_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse_len level=%b press=%b any=%b want 1111 0000 0", level_a, press_a, any_a);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (level_a !== 4'h0 || press_a !== 4'h0 || rel_a !== 4'h0) begin
            errors++;
            $display("FAIL reset_async level=%b press=%b rel=%b want 0000", level_a, press_a, rel_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; in_a = 4'hF;
        step(3);
    endtask

    task automatic test_press_release;
        in_a = 4'b1110;
        step(4);
        checks++;
        if (level_a !== 4'h0 || press_a !== 4'h0) begin
            errors++;
            $display("FAIL pr_early level=%b press=%b want 0000 0000", level_a, press_a);
        end
        step(1);
        checks++;
        if (level_a !== 4'b0001 || press_a !== 4'b0001 || rel_a !== 4'h0) begin
            errors++;
            $display("FAIL pr_press level=%b press=%b rel=%b want 0001 0001 0000", level_a, press_a, rel_a);
        end
        step(1);
        checks++;
        if (press_a !== 4'h0 || level_a !== 4'b0001) begin
            errors++;
            $display("FAIL pr_press_len level=%b press=%b want 0001 0000", level_a, press_a);
        end
        step(14);
        in_a = 4'hF;
        step(4);
        checks++;
        if (level_a !== 4'b0001 || rel_a !== 4'h0) begin
            errors++;
            $display("FAIL pr_rel_early level=%b rel=%b want 0001 0000", level_a, rel_a);
        end
        step(1);
        checks++;
        if (level_a !== 4'h0 || rel_a !== 4'b0001 || press_a !== 4'h0) begin
            errors++;
            $display("FAIL pr_release level=%b rel=%b press=%b want 0000 0001 0000", level_a, rel_a, press_a);
        end
        step(1);
        checks++;
        if (rel_a !== 4'h0) begin
            errors++;
            $display("FAIL pr_rel_len rel=%b want 0000", rel_a);
        end
    endtask

    task automatic test_bounce;
        logic       pat [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] seen = 4'h0;
        for (int k = 0; k < 7; k++) begin
            in_a[0] = pat[k];
            step(1);
            seen |= press_a | rel_a;
        end
        repeat (8) begin
            step(1);
            seen |= press_a | rel_a;
        end
        checks++;
        if (level_a !== 4'h0 || seen !== 4'h0) begin
            errors++;
            $display("FAIL bounce_reject level=%b pulses=%b want 0000 0000", level_a, seen);
        end
        in_a[0] = 1'b0;
        step(4);
        in_a[0] = 1'b1;
        step(1);
        checks++;
        if (level_a !== 4'b0001 || press_a !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_min_width level=%b press=%b want 0001 0001", level_a, press_a);
        end
        step(8);
        checks++;
        if (level_a !== 4'h0) begin
            errors++;
            $display("FAIL bounce_settle level=%b want 0000", level_a);
        end
    endtask

    task automatic test_prescaler;
        int m, n, lat;
        m = ecnt;
        n = m + 3;
        while (n % 4 != 0) n++;
        n += 8;
        in_d[1] = 1'b0;
        lat = 0;
        while (lat < 20 && level_d[1] !== 1'b1) begin
            step(1);
            lat++;
        end
        checks++;
        if (lat != n - m || lat < 11 || lat > 14) begin
            errors++;
            $display("FAIL div_latency edges=%0d want %0d", lat, n - m);
        end
        checks++;
        if (press_d !== 4'b0010 || rel_d !== 4'h0 || any_d !== 1'b1) begin
            errors++;
            $display("FAIL div_press press=%b rel=%b any=%b want 0010 0000 1", press_d, rel_d, any_d);
        end
        in_d[1] = 1'b1;
        step(20);
        for (int k = 0; k < 4 && ecnt % 4 != 0; k++) step(1);
        in_d[1] = 1'b0;
        step(4);
        in_d[1] = 1'b1;
        step(2);
        in_d[1] = 1'b0;
        step(13);
        checks++;
        if (level_d !== 4'h0) begin
            errors++;
            $display("FAIL div_glitch_early level=%b want 0000", level_d);
        end
        step(1);
        checks++;
        if (level_d !== 4'b0010 || press_d !== 4'b0010) begin
            errors++;
            $display("FAIL div_glitch_restart level=%b press=%b want 0010 0010", level_d, press_d);
        end
        in_d[1] = 1'b1;
        step(20);
    endtask

    task automatic test_simultaneous;
        int anyc = 0;
        in_a = 4'b0011;
        step(4);
        checks++;
        if (level_a !== 4'h0) begin
            errors++;
            $display("FAIL sim_early level=%b want 0000", level_a);
        end
        step(1);
        checks++;
        if (press_a !== 4'b1100 || any_a !== 1'b1 || level_a !== 4'b1100) begin
            errors++;
            $display("FAIL sim_press press=%b any=%b level=%b want 1100 1 1100", press_a, any_a, level_a);
        end
        repeat (6) begin
            step(1);
            anyc += int'(any_a);
        end
        checks++;
        if (anyc != 0) begin
            errors++;
            $display("FAIL sim_any_once extra=%0d want 0", anyc);
        end
        in_a = 4'b0111;
        step(5);
        checks++;
        if (rel_a !== 4'b0100 || press_a !== 4'h0 || level_a !== 4'b1000) begin
            errors++;
            $display("FAIL sim_release rel=%b press=%b level=%b want 0100 0000 1000", rel_a, press_a, level_a);
        end
        in_a = 4'hF;
        step(8);
    endtask

    task automatic test_polarity_reset;
        int pc = 0;
        in_p[0] = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        checks++;
        if (level_p !== 4'h0 || press_p !== 4'h0) begin
            errors++;
            $display("FAIL pol_in_reset level=%b press=%b want 0000 0000", level_p, press_p);
        end
        rst = 1'b0;
        step(4);
        checks++;
        if (level_p !== 4'h0 || press_p !== 4'h0) begin
            errors++;
            $display("FAIL pol_early level=%b press=%b want 0000 0000", level_p, press_p);
        end
        step(1);
        checks++;
        if (level_p !== 4'b0001 || press_p !== 4'b0001 || any_p !== 1'b1 || rel_p !== 4'h0) begin
            errors++;
            $display("FAIL pol_press level=%b press=%b any=%b rel=%b want 0001 0001 1 0000", level_p, press_p, any_p, rel_p);
        end
        repeat (10) begin
            step(1);
            pc += int'(press_p[0]);
        end
        checks++;
        if (pc != 0 || level_p !== 4'b0001) begin
            errors++;
            $display("FAIL pol_once extra=%0d level=%b want 0 0001", pc, level_p);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_prescaler();
        test_simultaneous();
        test_polarity_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
